// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller with one outstanding BUS_LOAD miss.
// Define ICACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module icache_ctrl #(
  parameter int XLEN      = 32,
  parameter int NUM_LINES = 32,
  parameter int MEM_TAG_W = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [XLEN-1:0]      proc2Icache_addr,
  input  logic                 proc2Icache_req,
  input  logic                 icache_flush,
  input  logic [MEM_TAG_W-1:0] mem2proc_transaction_tag,
  input  logic [63:0]          mem2proc_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_data_tag,
  output logic [1:0]           proc2mem_command,
  output logic [XLEN-1:0]      proc2mem_addr,
  output logic [63:0]          Icache2proc_data,
  output logic                 Icache2proc_data_valid,
  output logic                 icache_busy
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = XLEN - 3 - IDX_W;

  localparam logic [1:0] BUS_NONE = 2'h0;
  localparam logic [1:0] BUS_LOAD = 2'h1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [XLEN-1:0]       miss_addr_q, miss_addr_d;
  logic [MEM_TAG_W-1:0]  pend_tag_q, pend_tag_d;
  logic                  discard_q, discard_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [1:0]            mem_cmd_q, mem_cmd_d;
  logic [XLEN-1:0]       mem_addr_q, mem_addr_d;
  logic                  busy_q, busy_d;

  logic [63:0]           data_q [NUM_LINES];
  logic [TAG_W-1:0]      tags_q [NUM_LINES];

  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic                  line_match;
  logic                  hit;
  logic                  fill_we;
  logic                  unused_offset_bits;

  assign req_idx  = proc2Icache_addr[3+IDX_W-1:3];
  assign req_tag  = proc2Icache_addr[XLEN-1:3+IDX_W];
  assign fill_idx = miss_addr_q[3+IDX_W-1:3];
  assign fill_tag = miss_addr_q[XLEN-1:3+IDX_W];
  assign unused_offset_bits = ^proc2Icache_addr[2:0];

  // Lookup is purely combinational so a hit returns in the request cycle.
  assign line_match = valid_q[req_idx] && (tags_q[req_idx] == req_tag);
  assign hit        = proc2Icache_req && line_match && !icache_flush;

  assign Icache2proc_data_valid = hit;
  assign Icache2proc_data       = hit ? data_q[req_idx] : 64'h0;

  assign proc2mem_command = mem_cmd_q;
  assign proc2mem_addr    = mem_addr_q;
  assign icache_busy      = busy_q;

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    pend_tag_d  = pend_tag_q;
    discard_d   = discard_q;
    fill_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (proc2Icache_req && !line_match && !icache_flush) begin
          miss_addr_d = {proc2Icache_addr[XLEN-1:3], 3'b000};
          state_d     = REQ;
        end
      end
      REQ: begin
        if (icache_flush) begin
          state_d = IDLE;
        end else if (mem2proc_transaction_tag != '0) begin
          pend_tag_d = mem2proc_transaction_tag;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (icache_flush) begin
          discard_d = 1'b1;
        end
        // A flush in the completing cycle suppresses the write just like a stored discard.
        if ((pend_tag_q != '0) && (mem2proc_data_tag == pend_tag_q)) begin
          fill_we    = !discard_q && !icache_flush;
          discard_d  = 1'b0;
          pend_tag_d = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    valid_d = valid_q;
    if (icache_flush) begin
      valid_d = '0;
    end else if (fill_we) begin
      valid_d[fill_idx] = 1'b1;
    end

    mem_cmd_d  = (state_d == REQ) ? BUS_LOAD : BUS_NONE;
    mem_addr_d = (state_d == REQ) ? miss_addr_d : '0;
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      pend_tag_q  <= '0;
      discard_q   <= 1'b0;
      valid_q     <= '0;
      mem_cmd_q   <= BUS_NONE;
      mem_addr_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      pend_tag_q  <= pend_tag_d;
      discard_q   <= discard_d;
      valid_q     <= valid_d;
      mem_cmd_q   <= mem_cmd_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= busy_d;
    end
  end

  // Line payloads need no reset; valid_q gates every read of them.
  always_ff @(posedge clock) begin
    if (fill_we) begin
      data_q[fill_idx] <= mem2proc_data;
      tags_q[fill_idx] <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit && (hit_count_q != 32'hFFFF_FFFF)) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if ((state_q == IDLE) && (state_d == REQ) && (miss_count_q != 32'hFFFF_FFFF)) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed self-checking bench for icache_ctrl: misses, hits, backpressure,
// redirect, flush and asynchronous reset in the middle of a miss.
module tb_icache_ctrl;

  logic        clock;
  logic        reset;
  logic [31:0] proc2Icache_addr;
  logic        proc2Icache_req;
  logic        icache_flush;
  logic [3:0]  mem2proc_transaction_tag;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_data_tag;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] Icache2proc_data;
  logic        Icache2proc_data_valid;
  logic        icache_busy;

  int totalChecks;
  int badChecks;

  localparam logic [63:0] D0 = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D2 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] D3 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D4 = 64'hFEED_FACE_CAFE_BABE;
  localparam logic [63:0] JUNK = 64'h5555_5555_5555_5555;

  icache_ctrl dut (
    .clock                    (clock),
    .reset                    (reset),
    .proc2Icache_addr         (proc2Icache_addr),
    .proc2Icache_req          (proc2Icache_req),
    .icache_flush             (icache_flush),
    .mem2proc_transaction_tag (mem2proc_transaction_tag),
    .mem2proc_data            (mem2proc_data),
    .mem2proc_data_tag        (mem2proc_data_tag),
    .proc2mem_command         (proc2mem_command),
    .proc2mem_addr            (proc2mem_addr),
    .Icache2proc_data         (Icache2proc_data),
    .Icache2proc_data_valid   (Icache2proc_data_valid),
    .icache_busy              (icache_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic req, input logic flush,
                               input logic [3:0] ttag, input logic [3:0] dtag, input logic [63:0] data);
    proc2Icache_addr         = addr;
    proc2Icache_req          = req;
    icache_flush             = flush;
    mem2proc_transaction_tag = ttag;
    mem2proc_data_tag        = dtag;
    mem2proc_data            = data;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs a complete miss for addr and leaves the cache idle with the line filled.
  task automatic doFill(input logic [31:0] addr, input logic [3:0] tag, input logic [63:0] data);
    applyStimulus(addr, 1'b1, 1'b0, 4'd0, 4'd0, 64'h0);
    tick();
    applyStimulus(addr, 1'b1, 1'b0, tag, 4'd0, 64'h0);
    tick();
    applyStimulus(addr, 1'b1, 1'b0, 4'd0, tag, data);
    tick();
    applyStimulus(addr, 1'b1, 1'b0, 4'd0, 4'd0, 64'h0);
    #1;
  endtask

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    reset = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0, 4'd0, 4'd0, 64'h0);
    #12;
    checkOutput("rst_cmd",   64'(proc2mem_command), 64'd0);
    checkOutput("rst_addr",  64'(proc2mem_addr), 64'd0);
    checkOutput("rst_valid", 64'(Icache2proc_data_valid), 64'd0);
    checkOutput("rst_data",  Icache2proc_data, 64'd0);
    checkOutput("rst_busy",  64'(icache_busy), 64'd0);
    reset = 1'b1;
    tick();

    // Cold miss on 0x100
    applyStimulus(32'h0000_0100, 1'b1, 1'b0, 4'd0, 4'd0, 64'h0);
    #1;
    checkOutput("cold_miss_valid", 64'(Icache2proc_data_valid), 64'd0);
    tick();
    checkOutput("cold_req_cmd",  64'(proc2mem_command), 64'd1);
    checkOutput("cold_req_addr", 64'(proc2mem_addr), 64'h100);
    checkOutput("cold_req_busy", 64'(icache_busy), 64'd1);
    mem2proc_transaction_tag = 4'd3;
    tick();
    mem2proc_transaction_tag = 4'd0;
    #1;
    checkOutput("cold_wait_cmd",  64'(proc2mem_command), 64'd0);
    checkOutput("cold_wait_addr", 64'(proc2mem_addr), 64'd0);
    tick();
    mem2proc_data_tag = 4'd5;
    mem2proc_data     = JUNK;
    #1;
    checkOutput("cold_pre_valid", 64'(Icache2proc_data_valid), 64'd0);
    tick();
    checkOutput("foreign_tag_busy", 64'(icache_busy), 64'd1);
    mem2proc_data_tag = 4'd3;
    mem2proc_data     = D0;
    tick();
    mem2proc_data_tag = 4'd0;
    mem2proc_data     = 64'h0;
    #1;
    checkOutput("cold_fill_valid", 64'(Icache2proc_data_valid), 64'd1);
    checkOutput("cold_fill_data",  Icache2proc_data, D0);
    checkOutput("cold_fill_busy",  64'(icache_busy), 64'd0);

    // Same-line hit with a different offset
    proc2Icache_addr = 32'h0000_0104;
    #1;
    checkOutput("hit_valid", 64'(Icache2proc_data_valid), 64'd1);
    checkOutput("hit_data",  Icache2proc_data, D0);
    checkOutput("hit_cmd",   64'(proc2mem_command), 64'd0);

    // Backpressure: memory refuses for 5 cycles, accepts on the 6th
    applyStimulus(32'h0000_000C, 1'b1, 1'b0, 4'd0, 4'd0, 64'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_cmd%0d", i),  64'(proc2mem_command), 64'd1);
      checkOutput($sformatf("bp_addr%0d", i), 64'(proc2mem_addr), 64'h8);
      tick();
    end
    checkOutput("bp_cmd5", 64'(proc2mem_command), 64'd1);
    mem2proc_transaction_tag = 4'd2;
    tick();
    mem2proc_transaction_tag = 4'd0;
    #1;
    checkOutput("bp_wait_cmd",  64'(proc2mem_command), 64'd0);
    checkOutput("bp_wait_busy", 64'(icache_busy), 64'd1);
    mem2proc_data_tag = 4'd2;
    mem2proc_data     = D1;
    tick();
    mem2proc_data_tag = 4'd0;
    #1;
    checkOutput("bp_fill_data", Icache2proc_data, D1);

    // Redirect: fill 0x000, miss on 0x200, redirect back to 0x000 while waiting
    doFill(32'h0000_0000, 4'd1, D2);
    checkOutput("redir_base_data", Icache2proc_data, D2);
    proc2Icache_addr = 32'h0000_0200;
    #1;
    checkOutput("redir_miss_valid", 64'(Icache2proc_data_valid), 64'd0);
    tick();
    mem2proc_transaction_tag = 4'd4;
    tick();
    mem2proc_transaction_tag = 4'd0;
    proc2Icache_addr = 32'h0000_0010;
    #1;
    checkOutput("redir_other_miss", 64'(Icache2proc_data_valid), 64'd0);
    proc2Icache_addr = 32'h0000_0000;
    #1;
    checkOutput("redir_hit_valid", 64'(Icache2proc_data_valid), 64'd1);
    checkOutput("redir_hit_data",  Icache2proc_data, D2);
    mem2proc_data_tag = 4'd4;
    mem2proc_data     = D3;
    tick();
    mem2proc_data_tag = 4'd0;
    proc2Icache_addr  = 32'h0000_0200;
    #1;
    checkOutput("redir_fill_valid", 64'(Icache2proc_data_valid), 64'd1);
    checkOutput("redir_fill_data",  Icache2proc_data, D3);

    // Flush during WAIT discards the fill and invalidates resident lines
    applyStimulus(32'h0000_0018, 1'b1, 1'b0, 4'd0, 4'd0, 64'h0);
    tick();
    mem2proc_transaction_tag = 4'd6;
    tick();
    mem2proc_transaction_tag = 4'd0;
    proc2Icache_addr = 32'h0000_0200;
    icache_flush     = 1'b1;
    #1;
    checkOutput("flush_force_valid", 64'(Icache2proc_data_valid), 64'd0);
    tick();
    icache_flush     = 1'b0;
    proc2Icache_addr = 32'h0000_0018;
    mem2proc_data_tag = 4'd6;
    mem2proc_data     = D4;
    tick();
    mem2proc_data_tag = 4'd0;
    #1;
    checkOutput("flush_done_busy", 64'(icache_busy), 64'd0);
    checkOutput("flush_nowrite",   64'(Icache2proc_data_valid), 64'd0);
    tick();
    checkOutput("flush_remiss_busy", 64'(icache_busy), 64'd1);
    checkOutput("flush_remiss_cmd",  64'(proc2mem_command), 64'd1);
    proc2Icache_addr = 32'h0000_0200;
    #1;
    checkOutput("flush_old_line", 64'(Icache2proc_data_valid), 64'd0);
    applyStimulus(32'h0000_0200, 1'b0, 1'b1, 4'd0, 4'd0, 64'h0);
    tick();
    icache_flush = 1'b0;
    #1;
    checkOutput("flush_req_busy", 64'(icache_busy), 64'd0);
    checkOutput("flush_req_cmd",  64'(proc2mem_command), 64'd0);

    // Asynchronous reset between edges while a miss is in WAIT
    doFill(32'h0000_0008, 4'd1, D1);
    applyStimulus(32'h0000_0020, 1'b1, 1'b0, 4'd0, 4'd0, 64'h0);
    tick();
    mem2proc_transaction_tag = 4'd7;
    tick();
    mem2proc_transaction_tag = 4'd0;
    proc2Icache_addr = 32'h0000_0008;
    #1;
    checkOutput("ar_pre_valid", 64'(Icache2proc_data_valid), 64'd1);
    checkOutput("ar_pre_busy",  64'(icache_busy), 64'd1);
    reset = 1'b0;
    #1;
    checkOutput("ar_valid", 64'(Icache2proc_data_valid), 64'd0);
    checkOutput("ar_data",  Icache2proc_data, 64'd0);
    checkOutput("ar_busy",  64'(icache_busy), 64'd0);
    checkOutput("ar_cmd",   64'(proc2mem_command), 64'd0);
    reset = 1'b1;
    applyStimulus(32'h0000_0020, 1'b0, 1'b0, 4'd0, 4'd7, D4);
    tick();
    mem2proc_data_tag = 4'd0;
    #1;
    checkOutput("ar_stale_busy", 64'(icache_busy), 64'd0);
    proc2Icache_req = 1'b1;
    #1;
    checkOutput("ar_stale_nowrite", 64'(Icache2proc_data_valid), 64'd0);
    proc2Icache_addr = 32'h0000_0008;
    #1;
    checkOutput("ar_old_line", 64'(Icache2proc_data_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped instruction cache sitting directly upstream of ifetch.
- Accepts ifetch's proc2Icache_addr and returns a 64-bit block with Icache2proc_data / Icache2proc_data_valid.
- On a miss, issues a BUS_LOAD to memory and tracks the returned transaction tag. It writes the returning block into the line, then serves the hit.
- One outstanding miss at a time. Bus arbitration against the dcache lives above this block.

Parameters:
- NUM_LINES, 32, number of 8-byte lines; power of two. IDX_W = log2(NUM_LINES).
- MEM_TAG_W, 4, width of memory transaction tags. Tag value 0 means "no transaction".

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- proc2Icache_addr  in  XLEN  fetch address from ifetch. Bits [2:0] are ignored.
- proc2Icache_req  in  1  ifetch requests proc2Icache_addr this cycle.
- icache_flush  in  1  invalidate all lines (fence.i / recovery).
- mem2proc_transaction_tag  in  MEM_TAG_W  nonzero means the request driven this cycle was accepted.
- mem2proc_data  in  64  returning block.
- mem2proc_data_tag  in  MEM_TAG_W  tag of mem2proc_data; 0 means none.
- proc2mem_command  out  2  BUS_NONE or BUS_LOAD.
- proc2mem_addr  out  XLEN  block-aligned miss address; bits [2:0] are always 0.
- Icache2proc_data  out  64  block for proc2Icache_addr.
- Icache2proc_data_valid  out  1  Icache2proc_data is valid this cycle.
- icache_busy  out  1  FSM not in IDLE.

Behaviour:
- Address split: offset = [2:0], index = [3+IDX_W-1:3], tag = [XLEN-1:3+IDX_W].
- Storage is three register arrays: data[NUM_LINES][64], tags, and valid[NUM_LINES].
- Hit: proc2Icache_req & valid[index] & tag match & !icache_flush.
  - Icache2proc_data_valid and Icache2proc_data are combinational, so a hit has 0-cycle latency.
  - Icache2proc_data is 0 whenever Icache2proc_data_valid = 0.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: on proc2Icache_req & miss & !icache_flush, latch miss_addr = {addr[XLEN-1:3], 3'b0} and go to REQ.
  - REQ: drive proc2mem_command = BUS_LOAD and proc2mem_addr = miss_addr.
    - If mem2proc_transaction_tag != 0, latch it as pend_tag and go to WAIT.
    - Otherwise stay in REQ and retry every cycle, with no timeout.
  - WAIT: drive BUS_NONE. When mem2proc_data_tag == pend_tag and pend_tag != 0:
    - write data, tag and valid = 1 into line index(miss_addr), unless the discard flag is set;
    - clear discard and go to IDLE.
    - The written line is visible as a hit on the following cycle.
- Outside REQ: proc2mem_command = BUS_NONE and proc2mem_addr = 0.
- ifetch changing proc2Icache_addr during a miss (branch redirect): the in-flight fill still completes into the line for miss_addr and is not abandoned. The new address is looked up normally; on a miss it waits for IDLE before starting its own fill.
- Hits to other lines are served in every state, with no stall under a miss.
- icache_flush:
  - clears every valid bit at the clock edge;
  - forces Icache2proc_data_valid = 0 that cycle;
  - in REQ: returns to IDLE without latching a tag;
  - in WAIT: sets discard, so the returning data is consumed but not written.
- A fill completing in the same cycle as icache_flush is not written (flush wins).
- Tags from other requesters (mem2proc_data_tag != pend_tag) are ignored.
- Reset (asynchronous, active-low, any state including mid-miss):
  - valid[] = 0, FSM = IDLE, pend_tag = 0, discard = 0, miss_addr = 0;
  - all outputs 0 / BUS_NONE, icache_busy = 0.
  - A memory response arriving after reset deasserts is ignored (pend_tag = 0).

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0;
  - hit_count increments on each cycle with a hit;
  - miss_count increments on each IDLE->REQ transition;
  - both saturate at 32'hFFFF_FFFF and are unaffected by icache_flush.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Cold miss: reset, req addr 32'h0000_0100. Expect next cycle BUS_LOAD with proc2mem_addr 32'h0000_0100. Return transaction_tag 3, then 2 cycles later data_tag 3 with data 64'hDEAD_BEEF_0BAD_F00D. Expect valid=1 and that data the cycle after the fill.
- Hit after fill: req 32'h0000_0104 in the same line. Expect same-cycle valid=1, data 64'hDEAD_BEEF_0BAD_F00D, and command BUS_NONE.
- Backpressure: hold transaction_tag 0 for 5 cycles. Expect BUS_LOAD asserted all 5 cycles with a stable address. Tag 2 on cycle 6 leads to WAIT.
- Redirect mid-miss: miss on 32'h0000_0200, then switch addr to 32'h0000_0000 (resident) while in WAIT. Expect an immediate hit for 32'h0000_0000. The fill for 32'h0000_0200 still completes, and a later req to 32'h0000_0200 hits.
- Flush in WAIT: assert icache_flush during WAIT, then return the data tag. Expect no write: a subsequent req to the same address misses and icache_busy re-asserts. A previously resident line also misses.
- Async reset mid-miss: drop reset in WAIT between edges. Expect outputs 0 immediately. A stale data_tag after release causes no write, and valid stays 0.
